// File: rtl/lc4_divider_seq.sv
// Sequential restoring divider with a valid/ready request and result handshake.
// Handles signed (truncating) and unsigned division. A zero divisor completes
// immediately with a flagged zero result. BITS_PER_CYCLE quotient bits are
// resolved per busy cycle by an unrolled chain of shift-subtract stages.
module lc4_divider_seq #(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH:0]   div_reg;     // divisor magnitude, one extra bit so 2^(WIDTH-1) fits
    logic [WIDTH:0]   rem_reg;     // partial remainder
    logic [WIDTH-1:0] quo_reg;     // dividend magnitude shifting out, quotient shifting in
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic [WIDTH-1:0] q_out_reg;
    logic [WIDTH-1:0] r_out_reg;
    logic             dbz_reg;

    // Operand magnitudes at acceptance; the minimum negative value maps onto
    // its exact positive magnitude.
    logic             a_neg, b_neg, div_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH:0]   b_mag;

    assign a_neg    = i_signed & i_dividend[WIDTH-1];
    assign b_neg    = i_signed & i_divisor[WIDTH-1];
    assign a_mag    = a_neg ? -i_dividend : i_dividend;
    assign b_mag    = b_neg ? -{1'b1, i_divisor} : {1'b0, i_divisor};
    assign div_zero = (i_divisor == '0);

    // Unrolled restoring steps: stage 0 is the registered state, the last
    // stage is what gets written back at the end of a busy cycle.
    logic [WIDTH:0]   stage_rem [0:BITS_PER_CYCLE];
    logic [WIDTH-1:0] stage_quo [0:BITS_PER_CYCLE];

    assign stage_rem[0] = rem_reg;
    assign stage_quo[0] = quo_reg;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            logic [WIDTH+1:0] shifted;
            logic             ge;
            assign shifted = {stage_rem[gi], stage_quo[gi][WIDTH-1]};
            assign ge      = (shifted >= {1'b0, div_reg});
            // Since the remainder stays below the divisor, the difference
            // fits in WIDTH+1 bits and the dropped top bit is always zero.
            assign stage_rem[gi+1] = ge ? (shifted[WIDTH:0] - div_reg) : shifted[WIDTH:0];
            assign stage_quo[gi+1] = {stage_quo[gi][WIDTH-2:0], ge};
        end
    endgenerate

    logic [WIDTH-1:0] q_final, r_final;
    assign q_final = neg_q_reg ? -stage_quo[BITS_PER_CYCLE] : stage_quo[BITS_PER_CYCLE];
    assign r_final = neg_r_reg ? -stage_rem[BITS_PER_CYCLE][WIDTH-1:0]
                               : stage_rem[BITS_PER_CYCLE][WIDTH-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_valid) state_next = div_zero ? DONE : BUSY;
            BUSY:    if (cnt_reg == CW'(N - 1)) state_next = DONE;
            DONE:    if (i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        o_ready = (state_reg == IDLE);
        o_valid = (state_reg == DONE);
    end

    // Datapath: capture operands, iterate, and publish the signed-corrected result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            div_reg   <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            q_out_reg <= '0;
            r_out_reg <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_valid) begin
                        cnt_reg   <= '0;
                        div_reg   <= b_mag;
                        rem_reg   <= '0;
                        quo_reg   <= a_mag;
                        neg_q_reg <= a_neg ^ b_neg;
                        neg_r_reg <= a_neg;
                        if (div_zero) begin
                            q_out_reg <= '0;
                            r_out_reg <= '0;
                            dbz_reg   <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    rem_reg <= stage_rem[BITS_PER_CYCLE];
                    quo_reg <= stage_quo[BITS_PER_CYCLE];
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(N - 1)) begin
                        q_out_reg <= q_final;
                        r_out_reg <= r_final;
                        dbz_reg   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_quotient    = q_out_reg;
    assign o_remainder   = r_out_reg;
    assign o_div_by_zero = dbz_reg;

endmodule

// File: tb/tb_lc4_divider_seq.sv
// Self-checking bench for lc4_divider_seq: directed cases on a 16-bit/1-bit
// instance, randomized cases on a 32-bit/4-bit instance, both checked against
// a plain-arithmetic reference model.
module tb_lc4_divider_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    bit          wide_sel = 1'b0;
    logic        tb_valid = 1'b0, tb_signed = 1'b0, tb_iready = 1'b0;
    logic [31:0] tb_a = '0, tb_b = '0;

    logic        r16, v16, z16, r32, v32, z32;
    logic [15:0] q16, rm16;
    logic [31:0] q32, rm32;

    logic        obs_ready, obs_valid, obs_dz;
    logic [31:0] obs_q, obs_r;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lc4_divider_seq #(.WIDTH(16), .BITS_PER_CYCLE(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .i_valid(tb_valid & ~wide_sel), .o_ready(r16), .i_signed(tb_signed),
        .i_dividend(tb_a[15:0]), .i_divisor(tb_b[15:0]),
        .o_valid(v16), .i_ready(tb_iready & ~wide_sel),
        .o_quotient(q16), .o_remainder(rm16), .o_div_by_zero(z16)
    );

    lc4_divider_seq #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .i_valid(tb_valid & wide_sel), .o_ready(r32), .i_signed(tb_signed),
        .i_dividend(tb_a), .i_divisor(tb_b),
        .o_valid(v32), .i_ready(tb_iready & wide_sel),
        .o_quotient(q32), .o_remainder(rm32), .o_div_by_zero(z32)
    );

    always_comb begin
        obs_ready = wide_sel ? r32 : r16;
        obs_valid = wide_sel ? v32 : v16;
        obs_dz    = wide_sel ? z32 : z16;
        obs_q     = wide_sel ? q32 : {16'h0, q16};
        obs_r     = wide_sel ? rm32 : {16'h0, rm16};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: interpret operands, divide with truncation toward zero
    // (remainder takes the dividend's sign), wrap to w bits.
    function automatic void ref_div(input int w, input bit sgn, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] q,
                                    output logic [31:0] r, output logic dz);
        longint m, av, bv;
        m  = (longint'(1) << w) - 1;
        av = longint'(a) & m;
        bv = longint'(b) & m;
        if (sgn) begin
            if (av >= (longint'(1) << (w - 1))) av = av - (longint'(1) << w);
            if (bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
        end
        if (bv == 0) begin
            q = '0; r = '0; dz = 1'b1;
        end else begin
            q  = 32'((av / bv) & m);
            r  = 32'((av % bv) & m);
            dz = 1'b0;
        end
    endfunction

    task automatic scramble();
        tb_a      = $urandom;
        tb_b      = $urandom;
        tb_signed = 1'($urandom_range(0, 1));
    endtask

    // One full request/result transaction on the selected instance.
    task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
        int          t, lat, w, exp_lat;
        logic [31:0] eq, er;
        logic        edz;
        w = wide_sel ? 32 : 16;
        ref_div(w, sgn, a, b, eq, er, edz);
        exp_lat = edz ? 1 : (wide_sel ? 9 : 17);
        t = 0;
        while (!obs_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("ready_before_req", 32'(obs_ready), 32'd1);
        tb_valid = 1'b1; tb_signed = sgn; tb_a = a; tb_b = b;
        @(posedge clk);
        @(negedge clk);
        tb_valid = 1'b0;
        scramble();
        lat = 1;
        while (!obs_valid && lat < 100) begin
            @(negedge clk);
            scramble();
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("quotient", obs_q, eq);
        check_eq("remainder", obs_r, er);
        check_eq("div_by_zero", 32'(obs_dz), 32'(edz));
        $display("[TB] w=%0d s=%0d a=%h b=%h -> q=%h r=%h dz=%0d lat=%0d", w, sgn, a, b,
                 obs_q, obs_r, obs_dz, lat);
        for (int i = 0; i < hold; i++) begin
            tb_valid = 1'b1;
            scramble();
            @(negedge clk);
            check_eq("hold_q", obs_q, eq);
            check_eq("hold_r", obs_r, er);
            check_eq("hold_valid", 32'(obs_valid), 32'd1);
            check_eq("hold_ready", 32'(obs_ready), 32'd0);
        end
        tb_valid  = 1'b0;
        tb_iready = 1'b1;
        @(negedge clk);
        tb_iready = 1'b0;
        check_eq("idle_valid", 32'(obs_valid), 32'd0);
        check_eq("idle_ready", 32'(obs_ready), 32'd1);
        check_eq("idle_q_held", obs_q, eq);
    endtask

    initial begin
        int          seen;
        logic [31:0] a, b;
        bit          s;

        // Reset state on both instances.
        repeat (2) @(negedge clk);
        check_eq("rst_valid16", 32'(v16), 32'd0);
        check_eq("rst_q16", 32'(q16), 32'd0);
        check_eq("rst_r16", 32'(rm16), 32'd0);
        check_eq("rst_dz16", 32'(z16), 32'd0);
        check_eq("rst_ready16", 32'(r16), 32'd1);
        check_eq("rst_valid32", 32'(v32), 32'd0);
        check_eq("rst_ready32", 32'(r32), 32'd1);
        rst_n = 1'b1;

        // Directed cases, 16-bit / 1 bit per cycle.
        wide_sel = 1'b0;
        run_op(1'b0, 32'd100, 32'd7, 0);
        run_op(1'b1, 32'hFFF9, 32'h0002, 0);
        run_op(1'b1, 32'h8000, 32'hFFFF, 0);
        run_op(1'b0, 32'h1234, 32'h0000, 0);
        run_op(1'b1, 32'h8000, 32'h0001, 0);
        run_op(1'b1, 32'h7FFF, 32'h8000, 0);
        run_op(1'b1, 32'h0007, 32'hFFFE, 0);
        run_op(1'b0, 32'hFFFF, 32'hFFFF, 10);

        // Reset in the middle of a busy operation discards it.
        run_op(1'b0, 32'd100, 32'd7, 0);
        tb_valid = 1'b1; tb_signed = 1'b0; tb_a = 32'h1234; tb_b = 32'h0003;
        @(posedge clk);
        tb_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(obs_valid), 32'd0);
        check_eq("midrst_q", obs_q, 32'd0);
        check_eq("midrst_r", obs_r, 32'd0);
        check_eq("midrst_dz", 32'(obs_dz), 32'd0);
        check_eq("midrst_ready", 32'(obs_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (obs_valid) seen++;
        end
        check_eq("no_valid_after_rst", 32'(seen), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 32'hFFFF, 32'h0001, 0);

        // Randomized cases, 32-bit / 4 bits per cycle.
        wide_sel = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 1000; k++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 15))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'h1;
                3: a = 32'h8000_0000;
                4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                5: b = b >> $urandom_range(1, 30);
                6: a = a >> $urandom_range(1, 30);
                default: ;
            endcase
            run_op(s, a, b, (k % 50 == 0) ? 3 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lc4_divider_seq.md
LC4_DIVIDER_SEQ -- requirements
Module: lc4_divider_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The module SHALL have parameter BITS_PER_CYCLE, default 1, giving the quotient bits resolved per busy cycle; legal values SHALL be 1, 2, 4 or 8, and WIDTH SHALL be a multiple of BITS_PER_CYCLE.
REQ-003 clk  input  1  single clock for the block; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 i_valid  input  1  the request operands are valid this cycle.
REQ-006 o_ready  output  1  the block can accept a request this cycle.
REQ-007 i_signed  input  1  1 = two's-complement divide, 0 = unsigned divide; sampled at acceptance.
REQ-008 i_dividend  input  WIDTH  dividend; sampled at acceptance.
REQ-009 i_divisor  input  WIDTH  divisor; sampled at acceptance.
REQ-010 o_valid  output  1  the result outputs hold a completed result.
REQ-011 i_ready  input  1  the consumer takes the result this cycle.
REQ-012 o_quotient  output  WIDTH  quotient.
REQ-013 o_remainder  output  WIDTH  remainder.
REQ-014 o_div_by_zero  output  1  the current result came from a zero divisor.

Function
REQ-015 The block SHALL be a three-state FSM with states IDLE, BUSY and DONE; o_ready SHALL be 1 only in IDLE, and o_valid SHALL be 1 only in DONE.
REQ-016 Acceptance SHALL occur on a rising edge where the state is IDLE and i_valid=1; operands and i_signed SHALL be registered on that edge, and later input changes SHALL have no effect.
REQ-017 On acceptance with a nonzero divisor, the next state SHALL be BUSY with the step counter cleared.
REQ-018 BUSY SHALL last exactly N = WIDTH/BITS_PER_CYCLE cycles, each performing BITS_PER_CYCLE restoring shift-subtract steps; the state SHALL then move to DONE, so o_valid rises N+1 edges after the accepting edge.
REQ-019 On acceptance with a zero divisor, the next state SHALL be DONE directly, with quotient 0, remainder 0 and o_div_by_zero=1; o_div_by_zero SHALL be 0 for every other result.
REQ-020 Unsigned mode SHALL produce floor quotient and remainder with remainder < divisor.
REQ-021 Signed mode SHALL divide the operand magnitudes, truncate toward zero, negate the quotient when the operand signs differ, and give the remainder the sign of the dividend.
REQ-022 The signed overflow case (most-negative / -1) SHALL yield quotient = most-negative and remainder 0, with no flag.
REQ-023 All internal arithmetic SHALL use WIDTH+1 bits so that magnitude 2^(WIDTH-1) is represented exactly.
REQ-024 In DONE, the outputs SHALL stay stable while i_ready=0 (backpressure of any length); on an edge with i_ready=1, the state SHALL return to IDLE.
REQ-025 A request SHALL NOT be accepted in the cycle its predecessor's result is consumed; the minimum spacing between acceptances is therefore N+2 cycles, or 2 cycles for a zero divisor.
REQ-026 o_quotient, o_remainder and o_div_by_zero SHALL be held at the last result, or at 0 since reset, whenever o_valid=0.

Reset
REQ-027 While rst_n=0, the state SHALL be IDLE and o_valid=0, o_quotient=0, o_remainder=0, o_div_by_zero=0; o_ready SHALL be 1 once the state is IDLE.
REQ-028 Asserting rst_n mid-BUSY or in DONE SHALL discard the operation; no o_valid SHALL appear for it after release.
REQ-029 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-030 WIDTH=16, BITS_PER_CYCLE=1, unsigned 100/7 -> o_valid exactly 17 edges after acceptance, q=14, r=2, div_by_zero=0.
REQ-031 Signed 0xFFF9/0x0002 (-7/2) -> q=0xFFFD, r=0xFFFF; signed 0x8000/0xFFFF -> q=0x8000, r=0x0000.
REQ-032 Unsigned 0x1234/0x0000 -> o_valid 1 edge after acceptance, q=0, r=0, div_by_zero=1.
REQ-033 Hold i_ready=0 for 10 cycles in DONE while driving new inputs -> outputs unchanged, o_ready=0; first i_ready=1 edge -> IDLE.
REQ-034 Assert rst_n=0 in BUSY cycle 5 -> outputs 0 immediately, no o_valid after release; a fresh 0xFFFF/0x0001 request then gives q=0xFFFF, r=0.
REQ-035 WIDTH=32, BITS_PER_CYCLE=4, 1,000 random signed and unsigned operands -> every result matches the reference model, with latency 9 edges.
